// File: rtl/sprite_compositor.sv
// sprite_compositor: N-channel sprite/background compositor with per-frame overlap detection and freeze/restart FSM.
// Optional macro SPR_MIRROR_EN enables per-channel horizontal mirroring via spr_flip.
module sprite_compositor #(
    parameter int NUM_SPR    = 2,
    parameter int SPR_W      = 72,
    parameter int SPR_H      = 105,
    parameter int CW         = 6,
    parameter int BG_SPLIT   = 320,
    parameter int BG_L       = 7,
    parameter int BG_R       = 8,
    parameter int FREEZE_FRM = 90
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  frame_clk,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    input  logic [NUM_SPR*10-1:0] spr_x,
    input  logic [NUM_SPR*10-1:0] spr_y,
    input  logic [NUM_SPR-1:0]    spr_en,
    input  logic [NUM_SPR-1:0]    spr_flip,
    output logic [NUM_SPR*7-1:0]  rom_row,
    output logic [NUM_SPR*7-1:0]  rom_col,
    input  logic [NUM_SPR*CW-1:0] rom_pix,
    output logic [CW-1:0]         color,
    output logic                  Freeze,
    output logic                  Restart,
    output logic                  collision
);
    localparam int FF  = (FREEZE_FRM < 1) ? 1 : FREEZE_FRM;
    localparam int FCW = $clog2(FF) + 1;

    typedef enum logic [1:0] {ST_RUN, ST_FREEZE, ST_RESTART} state_t;

    state_t               state, state_n;
    logic [FCW-1:0]       fcnt, fcnt_n;
    logic [NUM_SPR-1:0]   hit_d, hit_q, opaque;
    logic [NUM_SPR*7-1:0] row_d, col_d;
    logic [9:0]           drawx_q;
    logic [CW-1:0]        color_d;
    logic [7:0]           n_op;
    logic                 v0, frame_clk_d, fe, ovl, ovl_now, new_col;

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_ch
        logic [9:0] x, y;
        logic [6:0] dx, dy;
        assign x  = spr_x[g*10 +: 10];
        assign y  = spr_y[g*10 +: 10];
        // Offsets are below 128 whenever the channel hits, so 7-bit differences suffice
        assign dx = DrawX[6:0] - x[6:0];
        assign dy = DrawY[6:0] - y[6:0];
        assign hit_d[g] = spr_en[g]
            && {1'b0, DrawX} >= {1'b0, x} && {1'b0, DrawX} < {1'b0, x} + 11'(SPR_W)
            && {1'b0, DrawY} >= {1'b0, y} && {1'b0, DrawY} < {1'b0, y} + 11'(SPR_H);
        assign row_d[g*7 +: 7] = hit_d[g] ? dy : 7'd0;
`ifdef SPR_MIRROR_EN
        assign col_d[g*7 +: 7] = hit_d[g] ? (spr_flip[g] ? 7'(SPR_W - 1) - dx : dx) : 7'd0;
`else
        assign col_d[g*7 +: 7] = hit_d[g] ? dx : 7'd0;
`endif
        assign opaque[g] = hit_q[g] && rom_pix[g*CW +: CW] != '0;
    end

`ifndef SPR_MIRROR_EN
    logic unused_flip;
    assign unused_flip = ^spr_flip;
`endif

    always_comb begin
        color_d = ({1'b0, drawx_q} < 11'(BG_SPLIT)) ? CW'(BG_L) : CW'(BG_R);
        n_op = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            color_d = opaque[i] ? rom_pix[i*CW +: CW] : color_d;
            n_op = n_op + 8'(opaque[i]);
        end
    end

    assign ovl_now = v0 && n_op >= 8'd2;
    assign fe      = frame_clk && !frame_clk_d;
    assign new_col = ovl || ovl_now;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_q       <= '0;
            rom_row     <= '0;
            rom_col     <= '0;
            drawx_q     <= '0;
            v0          <= 1'b0;
            color       <= CW'(BG_L);
            frame_clk_d <= 1'b0;
            ovl         <= 1'b0;
            collision   <= 1'b0;
        end else begin
            hit_q       <= hit_d;
            rom_row     <= row_d;
            rom_col     <= col_d;
            drawx_q     <= DrawX;
            v0          <= 1'b1;
            color       <= v0 ? color_d : color;
            frame_clk_d <= frame_clk;
            ovl         <= fe ? 1'b0 : new_col;
            collision   <= fe ? new_col : collision;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_RUN;
            fcnt  <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        case (state)
            ST_RUN: begin
                state_n = (fe && new_col) ? ST_FREEZE : ST_RUN;
                fcnt_n  = (fe && new_col) ? FCW'(FF - 1) : fcnt;
            end
            ST_FREEZE: begin
                state_n = (fe && fcnt == '0) ? ST_RESTART : ST_FREEZE;
                fcnt_n  = (fe && fcnt != '0) ? fcnt - 1'b1 : fcnt;
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign Freeze  = state == ST_FREEZE;
    assign Restart = state == ST_RESTART;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed and randomized checks of sprite_compositor against a frame-level reference model.
module tb_sprite_compositor;
    localparam int N  = 2;
    localparam int CW = 6;
    localparam int FF = 3;

    logic          Clk = 1'b0;
    logic          Reset, frame_clk;
    logic [9:0]    DrawX, DrawY;
    logic [N*10-1:0] spr_x, spr_y;
    logic [N-1:0]  spr_en, spr_flip;
    logic [N*7-1:0] rom_row, rom_col;
    logic [N*CW-1:0] rom_pix;
    logic [CW-1:0] color;
    logic          Freeze, Restart, collision;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_hit;
    int           m_dx, m_color, frz_left;
    bit           m_valid, m_ovl, m_coll, m_restart, fc_prev;

    sprite_compositor #(.FREEZE_FRM(FF)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .DrawX(DrawX), .DrawY(DrawY),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .spr_flip(spr_flip),
        .rom_row(rom_row), .rom_col(rom_col), .rom_pix(rom_pix), .color(color),
        .Freeze(Freeze), .Restart(Restart), .collision(collision)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hit = '0; m_dx = 0; m_color = 7; frz_left = 0;
        m_valid = 0; m_ovl = 0; m_coll = 0; m_restart = 0; fc_prev = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        model_reset();
        chk("rst_color", 32'(color), 7);
        chk("rst_freeze", 32'(Freeze), 0);
        chk("rst_restart", 32'(Restart), 0);
        chk("rst_collision", 32'(collision), 0);
        chk("rst_rom_row", 32'(rom_row), 0);
        chk("rst_rom_col", 32'(rom_col), 0);
        Reset = 1'b0;
    endtask

    // One clock: predict everything from current inputs, advance, compare.
    task automatic tick();
        int cnt, pick, x, y, c;
        bit ovl_now, fe, was_rst;
        logic [N*7-1:0] er, ec;
        cnt = 0; pick = -1;
        for (int i = N - 1; i >= 0; i--)
            if (m_hit[i] && rom_pix[i*CW +: CW] != 0) begin cnt++; pick = i; end
        if (m_valid) m_color = (pick >= 0) ? int'(rom_pix[pick*CW +: CW]) : (m_dx < 320 ? 7 : 8);
        ovl_now = m_valid && cnt >= 2;
        fe = frame_clk && !fc_prev;
        fc_prev = frame_clk;
        was_rst = m_restart;
        m_restart = 0;
        if (fe) begin
            m_coll = m_ovl || ovl_now;
            m_ovl = 0;
            if (frz_left > 0) begin
                frz_left--;
                if (frz_left == 0) m_restart = 1;
            end else if (!was_rst && m_coll) frz_left = FF;
        end else m_ovl = m_ovl || ovl_now;
        er = '0; ec = '0;
        for (int i = 0; i < N; i++) begin
            x = int'(spr_x[i*10 +: 10]);
            y = int'(spr_y[i*10 +: 10]);
            m_hit[i] = spr_en[i] && DrawX >= x && DrawX < x + 72 && DrawY >= y && DrawY < y + 105;
`ifdef SPR_MIRROR_EN
            c = spr_flip[i] ? 71 - (DrawX - x) : DrawX - x;
`else
            c = DrawX - x;
`endif
            if (m_hit[i]) begin er[i*7 +: 7] = 7'(DrawY - y); ec[i*7 +: 7] = 7'(c); end
        end
        m_dx = DrawX;
        m_valid = 1;
        @(posedge Clk); #1;
        chk("color", 32'(color), 32'(m_color));
        chk("freeze", 32'(Freeze), 32'(frz_left > 0));
        chk("restart", 32'(Restart), 32'(m_restart));
        chk("collision", 32'(collision), 32'(m_coll));
        chk("rom_row", 32'(rom_row), 32'(er));
        chk("rom_col", 32'(rom_col), 32'(ec));
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 0; DrawX = 0; DrawY = 0;
        spr_x = '0; spr_y = '0; spr_en = '0; spr_flip = '0; rom_pix = '0;
        do_reset();

        DrawX = 319; DrawY = 10; tick();
        DrawX = 320; tick();
        chk("bg_left", 32'(color), 7);
        tick();
        chk("bg_right", 32'(color), 8);

        spr_x[9:0] = 100; spr_y[9:0] = 200; spr_en = 2'b01; rom_pix = 12'd5;
        DrawX = 100; DrawY = 200; tick();
        chk("row_origin", 32'(rom_row[6:0]), 0);
        chk("col_origin", 32'(rom_col[6:0]), 0);
        tick();
        chk("spr_color", 32'(color), 5);
        DrawX = 171; DrawY = 304; tick();
        chk("row_last", 32'(rom_row[6:0]), 104);
        chk("col_last", 32'(rom_col[6:0]), 71);
        DrawX = 172; tick(); tick();
        chk("outside_bg", 32'(color), 7);

        spr_x[19:10] = 110; spr_y[19:10] = 210; spr_en = 2'b11;
        DrawX = 120; DrawY = 220; rom_pix = {6'd12, 6'd0}; tick(); tick();
        chk("transp_fallthrough", 32'(color), 12);
        rom_pix = {6'd0, 6'd3}; tick();
        chk("priority", 32'(color), 3);
        frame_clk = 1; tick();
        chk("single_no_coll", 32'(collision), 0);
        chk("single_no_freeze", 32'(Freeze), 0);
        frame_clk = 0; tick();

        rom_pix = {6'd12, 6'd3}; tick();
        frame_clk = 1; tick();
        chk("coll_set", 32'(collision), 1);
        chk("freeze_set", 32'(Freeze), 1);
        frame_clk = 0; spr_en = 2'b00; rom_pix = '0;
        for (int k = 0; k < FF; k++) begin
            tick(); tick();
            frame_clk = 1; tick(); frame_clk = 0;
            if (k < FF - 1) chk("still_frozen", 32'(Freeze), 1);
        end
        chk("restart_pulse", 32'(Restart), 1);
        chk("freeze_end", 32'(Freeze), 0);
        tick();
        chk("restart_once", 32'(Restart), 0);
        chk("coll_cleared", 32'(collision), 0);

        spr_en = 2'b11; rom_pix = {6'd12, 6'd3}; tick(); tick();
        frame_clk = 1; tick(); frame_clk = 0;
        chk("refreeze", 32'(Freeze), 1);
        spr_en = 2'b00; rom_pix = '0; tick();
        frame_clk = 1; tick(); frame_clk = 0;
        chk("frozen_frame2", 32'(Freeze), 1);
        tick();
        do_reset();

        spr_flip = 2'b01; spr_en = 2'b01; spr_x[9:0] = 100; spr_y[9:0] = 200;
        DrawX = 100; DrawY = 200; tick();
`ifdef SPR_MIRROR_EN
        chk("mirror_col", 32'(rom_col[6:0]), 71);
`else
        chk("mirror_col", 32'(rom_col[6:0]), 0);
`endif
        spr_flip = 2'b00; spr_x[9:0] = 1000; DrawX = 10; DrawY = 210; tick();
        chk("no_wrap", 32'(rom_col[6:0]), 0);
        DrawX = 1020; tick();
        chk("edge_1020", 32'(rom_col[6:0]), 20);

        for (int n = 0; n < 800; n++) begin
            DrawX = 10'($urandom_range(0, 1023));
            DrawY = 10'($urandom_range(0, 1023));
            for (int i = 0; i < N; i++) begin
                int ox, oy;
                ox = $urandom_range(0, 90);
                oy = $urandom_range(0, 120);
                spr_x[i*10 +: 10] = (DrawX >= ox) ? 10'(DrawX - ox) : 10'($urandom);
                spr_y[i*10 +: 10] = (DrawY >= oy) ? 10'(DrawY - oy) : 10'($urandom);
                rom_pix[i*CW +: CW] = $urandom_range(0, 1) ? CW'($urandom) : '0;
            end
            spr_en = N'($urandom);
            spr_flip = N'($urandom);
            frame_clk = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
